simple_logic_ff_tester: RTL

Self-checking stimulus and response block for the registered simple_logic_ff netlist. It drives the DUT inputs a/b/c/d and consumes the DUT output out. Vectors run exhaustively from a counter. A delay-matched golden model computes the expected out = (a|b)&(c|d), and the block counts mismatches. It sits beside simple_logic_ff on the same clk, for mapped-netlist equivalence checking in silicon or in simulation.

---
 rtl/simple_logic_pkg.sv | 32 +++
 rtl/simple_logic_exp_pipe.sv | 44 ++++
 rtl/simple_logic_ff_tester.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/simple_logic_pkg.sv
// simple_logic_pkg
//   Shared definitions for the simple_logic_ff tester:
//   - state_t      : tester FSM states
//   - IDX_W        : width of a vector index
//   - exp_entry_t  : one entry of the expected-value pipe
//   - golden_f     : reference function of the simple_logic_ff netlist
package simple_logic_pkg;

  localparam int IDX_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One in-flight expectation: which vector it belongs to and what the
  // DUT must produce for it. valid=0 entries are bubbles and never compared.
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic             expected;
  } exp_entry_t;

  // Combinational function the registered netlist implements.
  function automatic logic golden_f(input logic a, input logic b,
                                    input logic c, input logic d);
    return (a | b) & (c | d);
  endfunction

endpackage

// File: rtl/simple_logic_exp_pipe.sv
// simple_logic_exp_pipe
//   LATENCY-deep shift register of expected-value entries. It delays each
//   expectation by the same number of edges the DUT needs, so the tail entry
//   lines up with dut_out at the compare edge.
// Ports:
//   clk   in  clock, rising edge
//   rst   in  asynchronous active-high clear of every stage
//   clear in  synchronous clear of every stage (run start)
//   push  in  entry shifted into stage 0 on every edge
//   tail  out oldest stage, the entry due for comparison
module simple_logic_exp_pipe
  import simple_logic_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  exp_entry_t push,
  output exp_entry_t tail
);

  exp_entry_t stage [LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LATENCY; k++) begin
        stage[k] <= '0;
      end
    end else if (clear) begin
      for (int k = 0; k < LATENCY; k++) begin
        stage[k] <= '0;
      end
    end else begin
      stage[0] <= push;
      for (int k = 1; k < LATENCY; k++) begin
        stage[k] <= stage[k-1];
      end
    end
  end

  assign tail = stage[LATENCY-1];

endmodule

// File: rtl/simple_logic_ff_tester.sv
// simple_logic_ff_tester
//   Exhaustive stimulus/response checker for the registered simple_logic_ff
//   netlist. Vector i drives {a,b,c,d} = i[3:0] (a is bit 3). A delay-matched
//   golden pipe supplies the expected out, and mismatches are counted in a
//   saturating counter with the index of the first failing vector kept.
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   level-sampled start request, honoured in IDLE/DONE only
//   dut_a..d   out  DUT inputs
//   dut_out    in   DUT output
//   busy       out  high in RUN and DRAIN
//   done       out  high in DONE until the next accepted start
//   pass       out  done with zero mismatches
//   err_count  out  saturating mismatch count
//   first_fail out  index of first mismatching vector (valid if err_count!=0)
//   state      out  current FSM state, for observation
//
// Handshake: there is no valid/ready pair; start is a plain level that is
// acted on at any rising edge where the FSM is in IDLE or DONE, and ignored
// otherwise.
module simple_logic_ff_tester
  import simple_logic_pkg::*;
#(
  parameter int NUM_VEC = 16,
  parameter int LATENCY = 2,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  output logic             dut_c,
  output logic             dut_d,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [IDX_W-1:0] first_fail,
  output state_t           state
);

  localparam int               DRN_W      = 4;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_VEC - 1);
  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(LATENCY - 1);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  state_t           state_nxt;
  logic [IDX_W-1:0] vec_cnt;
  logic [IDX_W-1:0] vec_cnt_nxt;
  logic [DRN_W-1:0] drain_cnt;
  logic [DRN_W-1:0] drain_cnt_nxt;
  logic [3:0]       vec_drv;       // {a,b,c,d} currently on the DUT inputs
  logic [3:0]       vec_drv_nxt;
  logic             start_accept;
  logic             push_valid;
  exp_entry_t       push_entry;
  exp_entry_t       tail_entry;
  logic             mismatch;

  // ---------------------------------------------------------------------
  // FSM state and counters
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      vec_cnt   <= '0;
      drain_cnt <= '0;
      vec_drv   <= '0;
    end else begin
      state     <= state_nxt;
      vec_cnt   <= vec_cnt_nxt;
      drain_cnt <= drain_cnt_nxt;
      vec_drv   <= vec_drv_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    vec_cnt_nxt   = vec_cnt;
    drain_cnt_nxt = drain_cnt;
    vec_drv_nxt   = vec_drv;
    start_accept  = 1'b0;
    push_valid    = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt     = RUN;
          vec_cnt_nxt   = '0;
          drain_cnt_nxt = '0;
          vec_drv_nxt   = 4'h0;
          start_accept  = 1'b1;
        end
      end

      RUN: begin
        // The vector on the pins now (index vec_cnt) enters the pipe at
        // this edge, while the next vector replaces it on the pins.
        push_valid = 1'b1;
        if (vec_cnt == LAST_IDX) begin
          state_nxt     = DRAIN;
          vec_drv_nxt   = 4'h0;
          drain_cnt_nxt = '0;
        end else begin
          vec_cnt_nxt = vec_cnt + IDX_W'(1);
          vec_drv_nxt = vec_cnt_nxt[3:0];
        end
      end

      DRAIN: begin
        // The entry edge plus LATENCY further edges flush the last vector
        // through the pipe; its compare happens on the edge leaving DRAIN.
        if (drain_cnt == DRAIN_LAST) begin
          state_nxt = DONE;
        end else begin
          drain_cnt_nxt = drain_cnt + DRN_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Expected-value pipe
  // ---------------------------------------------------------------------
  always_comb begin
    push_entry          = '0;
    push_entry.valid    = push_valid;
    push_entry.idx      = vec_cnt;
    push_entry.expected = golden_f(vec_drv[3], vec_drv[2], vec_drv[1], vec_drv[0]);
  end

  simple_logic_exp_pipe #(
    .LATENCY (LATENCY)
  ) u_exp_pipe (
    .clk   (clk),
    .rst   (rst),
    .clear (start_accept),
    .push  (push_entry),
    .tail  (tail_entry)
  );

  // ---------------------------------------------------------------------
  // Compare and error accounting
  // ---------------------------------------------------------------------
  assign mismatch = tail_entry.valid && (dut_out != tail_entry.expected);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count  <= '0;
      first_fail <= '0;
    end else if (start_accept) begin
      err_count  <= '0;
      first_fail <= '0;
    end else if (mismatch) begin
      // Once saturated, the count holds and first_fail is already latched.
      if (err_count != ERR_MAX) begin
        err_count <= err_count + ERR_W'(1);
      end
      if (err_count == '0) begin
        first_fail <= tail_entry.idx;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign dut_a = vec_drv[3];
  assign dut_b = vec_drv[2];
  assign dut_c = vec_drv[1];
  assign dut_d = vec_drv[0];

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

endmodule
